hazard_scoreboard: RTL
======================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; 0 clears all state immediately.
- d_rs  input  5  rs field of the D-stage instruction.
- d_rt  input  5  rt field of the D-stage instruction.
- d_tuse_rs  input  2  cycles until D needs rs; 3 = rs not read.
- d_tuse_rt  input  2  cycles until D needs rt; 3 = rt not read.
- d_a3  input  5  destination register of the D-stage instruction; 0 = no write.
- d_tnew  input  2  cycles after entering E until the result is produced.
- d_md  input  1  D instruction uses HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
- d_md_start  input  1  D instruction is mult/multu/div/divu.
- d_is_div  input  1  qualifies d_md_start: 1 = div class, 0 = mult class.
- stall  output  1  freeze PC and F/D register.
- e_clr  output  1  load a bubble into the D/E register.
- e_ready  output  1  E-stage result is available for forwarding (E tnew == 0).
- m_ready  output  1  M-stage result is available for forwarding (M tnew == 0).
- md_busy  output  1  multiply/divide unit is occupied.

Function
REQ-002 The block SHALL hold three entries, E, M and W, each containing {a3[4:0], tnew[1:0]}.
REQ-003 When stall=0, each rising edge SHALL load E <= {d_a3, d_tnew}.
REQ-004 When stall=1, each rising edge SHALL load E <= {0, 0} (bubble).
REQ-005 Each rising edge SHALL load M <= {E.a3, sat_dec(E.tnew)} and W <= {M.a3, sat_dec(M.tnew)}, where sat_dec(0) = 0.
REQ-006 stall_rs SHALL equal: d_tuse_rs != 3 AND d_rs != 0 AND ((d_rs == E.a3 AND E.tnew > d_tuse_rs) OR (d_rs == M.a3 AND M.tnew > d_tuse_rs)); comparisons are unsigned.
REQ-007 stall_rt SHALL be defined identically to stall_rs, using d_rt and d_tuse_rt.
REQ-008 The W entry SHALL never cause a stall.
REQ-009 A register flag e_md SHALL load (d_md_start AND NOT stall) each edge, and a register e_div SHALL load d_is_div at the same edge.
REQ-010 A 4-bit counter md_cnt SHALL behave as follows each edge:
- if e_md=1: load 10 when e_div=1, else 5;
- else if md_cnt != 0: decrement by 1;
- else: hold 0.
REQ-011 md_busy SHALL equal (md_cnt != 0).
REQ-012 stall_md SHALL equal d_md AND (e_md OR md_busy).
REQ-013 stall SHALL equal stall_rs OR stall_rt OR stall_md, computed combinationally from registered state and current D inputs with zero latency.
REQ-014 e_clr SHALL equal stall.
REQ-015 e_ready SHALL equal (E.tnew == 0), and m_ready SHALL equal (M.tnew == 0).
REQ-016 An md_start arriving while md_busy=1 SHALL never be accepted, because stall_md holds it in D.

Reset
REQ-017 While reset=0, all entries SHALL be {0,0}, md_cnt=0, e_md=0 and e_div=0, asynchronously and regardless of clk.
REQ-018 While reset=0, the outputs SHALL be stall=0, e_clr=0, md_busy=0, e_ready=1 and m_ready=1.
REQ-019 Asserting reset in mid-operation (e.g. md_cnt=7) SHALL clear busy and stall in the same cycle, with no residual count after release.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Load-use: accept d_a3=8, d_tnew=2; next cycle d_rs=8, d_tuse_rs=1 -> stall=1 for exactly 1 cycle, E becomes a bubble; next cycle M.tnew=1 -> stall=0.
- ALU-to-branch: accept d_a3=5, d_tnew=1; next cycle d_rt=5, d_tuse_rt=0 -> stall=1 for 1 cycle, then stall=0 with m_ready=1.
- Zero register and unused operand: E={0,2} with d_rs=0 -> stall=0; E={9,2} with d_rs=9 and d_tuse_rs=3 -> stall=0.
- Mult then mflo: accept d_md_start=1, d_is_div=0; mflo held in D -> stall=1 for 6 consecutive cycles (1 for e_md, 5 for md_cnt 5..1); repeat with div -> 11 cycles.
- Reset mid-divide: md_cnt=7, reset=0 -> md_busy=0 and stall=0 immediately; after release with d_md=1 -> stall=0.
- Stall priority: stall_rs and stall_md both true in one cycle -> single stall=1, and E is loaded with one bubble only.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destination/tnew of E, M and W, and the
// multiply/divide busy window, and decides D-stage stalls combinationally.
module hazard_scoreboard (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_rs,
  input  logic [4:0] d_rt,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic [4:0] d_a3,
  input  logic [1:0] d_tnew,
  input  logic       d_md,
  input  logic       d_md_start,
  input  logic       d_is_div,
  output logic       stall,
  output logic       e_clr,
  output logic       e_ready,
  output logic       m_ready,
  output logic       md_busy
);

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  logic [4:0] e_a3, m_a3, w_a3;
  logic [1:0] e_tnew, m_tnew, w_tnew;
  logic       e_md, e_div;
  logic [3:0] md_cnt;
  logic       stall_rs, stall_rt, stall_md;

  function automatic logic [1:0] sat_dec(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A source hazards when a younger-than-W producer will not have its result
  // ready by the time D needs it; tuse of 3 marks an operand that is not read.
  function automatic logic src_hazard(input logic [4:0] rs, input logic [1:0] tuse,
                                      input logic [4:0] ea3, input logic [1:0] etn,
                                      input logic [4:0] ma3, input logic [1:0] mtn);
    return (tuse != 2'd3) && (rs != 5'd0) &&
           (((rs == ea3) && (etn > tuse)) || ((rs == ma3) && (mtn > tuse)));
  endfunction

  always_comb begin
    stall_rs = src_hazard(d_rs, d_tuse_rs, e_a3, e_tnew, m_a3, m_tnew);
    stall_rt = src_hazard(d_rt, d_tuse_rt, e_a3, e_tnew, m_a3, m_tnew);
    stall_md = d_md && (e_md || md_busy);
    stall    = stall_rs || stall_rt || stall_md;
    e_clr    = stall;
    e_ready  = (e_tnew == 2'd0);
    m_ready  = (m_tnew == 2'd0);
  end

  assign md_busy = (md_cnt != 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_a3   <= 5'd0;
      e_tnew <= 2'd0;
      m_a3   <= 5'd0;
      m_tnew <= 2'd0;
      w_a3   <= 5'd0;
      w_tnew <= 2'd0;
      e_md   <= 1'b0;
      e_div  <= 1'b0;
      md_cnt <= 4'd0;
    end else begin
      if (stall) begin
        e_a3   <= 5'd0;
        e_tnew <= 2'd0;
      end else begin
        e_a3   <= d_a3;
        e_tnew <= d_tnew;
      end
      m_a3   <= e_a3;
      m_tnew <= sat_dec(e_tnew);
      w_a3   <= m_a3;
      w_tnew <= sat_dec(m_tnew);
      // A stalled md_start never reaches E, so a busy unit is never restarted.
      e_md   <= d_md_start && !stall;
      e_div  <= d_is_div;
      if (e_md)
        md_cnt <= e_div ? DIV_CYCLES : MULT_CYCLES;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

endmodule
